// File: rtl/spec_ghr_checkpoint.sv
// rtl/spec_ghr_checkpoint.sv - speculative global branch history with in-order resolution and recovery
//
// Purpose:
//   Keeps two global branch histories. The speculative copy (ghr_out) takes
//   each predicted direction from fetch immediately. The architectural copy
//   (arch_out) takes each actual direction as execute resolves branches,
//   oldest first. A small FIFO holds the predicted bit of every in-flight
//   branch so that each resolve can be compared against its prediction.
//   On a mispredict or an external flush, the speculative history is rebuilt
//   from the architectural copy in a single cycle.
//
// Ports:
//   clk, rstn       rising-edge clock, asynchronous active-low reset
//   spec_en         fetch predicted a conditional branch this cycle
//   spec_taken      predicted direction (1 = taken)
//   spec_ready      FIFO can accept a branch (count < DEPTH)
//   res_en          execute resolves the oldest in-flight branch
//   res_taken       actual direction of that branch
//   res_mispredict  resolve disagrees with the stored prediction (combinational)
//   flush           discard all in-flight branches, rebuild speculative history
//   ghr_out         speculative history, registered
//   arch_out        committed history, registered
//   inflight_cnt    FIFO occupancy
//   err_underflow   one-cycle pulse after a resolve with an empty FIFO
module spec_ghr_checkpoint #(
  parameter int HIST_LEN = 8,
  parameter int DEPTH    = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         spec_en,
  input  logic                         spec_taken,
  output logic                         spec_ready,
  input  logic                         res_en,
  input  logic                         res_taken,
  output logic                         res_mispredict,
  input  logic                         flush,
  output logic [HIST_LEN-1:0]          ghr_out,
  output logic [HIST_LEN-1:0]          arch_out,
  output logic [$clog2(DEPTH+1)-1:0]   inflight_cnt,
  output logic                         err_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [HIST_LEN-1:0] ghr_q,    ghr_d;
  logic [HIST_LEN-1:0] arch_q,   arch_d;
  logic [DEPTH-1:0]    fifo_q,   fifo_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic                err_q,    err_d;

  logic empty;
  logic res_valid;
  logic spec_acc;
  logic recover;

  always_comb begin
    empty          = (cnt_q == '0);
    spec_ready     = (cnt_q < DEPTH_C);
    res_valid      = res_en & ~empty;
    res_mispredict = res_valid & (res_taken != fifo_q[rd_ptr_q]);
    // A mispredict and a flush have the same effect on ghr and the FIFO.
    recover        = flush | res_mispredict;
    spec_acc       = spec_en & spec_ready & ~recover;

    ghr_d    = ghr_q;
    arch_d   = arch_q;
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = res_en & empty;

    // A valid resolve always commits, even alongside a flush or mispredict.
    if (res_valid) begin
      arch_d = {res_taken, arch_q[HIST_LEN-1:1]};
    end

    if (recover) begin
      // Rebuild from the architectural history including this cycle's commit.
      ghr_d    = arch_d;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (spec_acc) begin
        ghr_d            = {spec_taken, ghr_q[HIST_LEN-1:1]};
        fifo_d[wr_ptr_q] = spec_taken;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (res_valid) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (spec_acc && !res_valid) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (!spec_acc && res_valid) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ghr_q    <= '0;
      arch_q   <= '0;
      fifo_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      ghr_q    <= ghr_d;
      arch_q   <= arch_d;
      fifo_q   <= fifo_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign ghr_out       = ghr_q;
  assign arch_out      = arch_q;
  assign inflight_cnt  = cnt_q;
  assign err_underflow = err_q;

  // Every speculative bit still unresolved is the only thing separating the
  // two histories, so with nothing in flight they must agree.
  a_empty_in_sync : assert property (@(posedge clk) disable iff (!rstn)
    (cnt_q == '0) |-> (ghr_q == arch_q));

endmodule

// File: doc/spec_ghr_checkpoint.md
# spec_ghr_checkpoint

Speculative global branch history register with in-order resolution buffer and misprediction recovery, successor to the 2-bit non-speculative history register in the 4-stage branch-prediction pipeline. Fetch shifts the predicted direction into a speculative history immediately. A FIFO tracks in-flight branch predictions. Execute resolves branches oldest-first, which commits them to an architectural history; on a mispredict or pipeline flush, the speculative history is rebuilt from the architectural copy in one cycle.

## Interface
- HIST_LEN, 8, history length in bits; ≥2
- DEPTH, 4, max in-flight unresolved branches; power of two, ≥2
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- spec_en  in  1  fetch predicted a conditional branch this cycle
- spec_taken  in  1  predicted direction (1 = taken)
- spec_ready  out  1  FIFO can accept a branch; combinational, = (count < DEPTH)
- res_en  in  1  execute resolves the oldest in-flight branch
- res_taken  in  1  actual direction
- res_mispredict  out  1  combinational; res_en & !empty & (res_taken != head predicted bit)
- flush  in  1  external pipeline flush (exception/redirect); discards all in-flight branches
- ghr_out  out  HIST_LEN  speculative history, registered
- arch_out  out  HIST_LEN  committed history, registered
- inflight_cnt  out  $clog2(DEPTH+1)  FIFO occupancy
- err_underflow  out  1  registered one-cycle pulse: res_en while FIFO empty

## Operation
- Shift rule, both histories: new bit enters the MSB and the old LSB is discarded, i.e. h <= {bit, h[HIST_LEN-1:1]}.
- FIFO entry holds only the predicted direction bit.
- Circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus a separate count.
- Spec accept (spec_acc) = spec_en & spec_ready & !flush & !res_mispredict.
  - On spec_acc: push spec_taken and shift spec_taken into ghr_out.
  - spec_en while spec_ready=0 is silently dropped. No state change.
- Resolve (res_en & !empty):
  - pop the head;
  - shift res_taken into arch_out;
  - count decrements unless a push is also accepted.
- Mispredict: ghr_out <= {res_taken, arch_out[HIST_LEN-1:1]}, i.e. equal to the new arch_out. The FIFO clears (pointers and count to 0), and a same-cycle spec_en is ignored.
- Resolve with res_en & empty: no state change, and err_underflow pulses next cycle.
- Flush:
  - ghr_out <= the arch_out value after this cycle's resolve (if any);
  - the FIFO clears;
  - spec is ignored.
  - A same-cycle valid resolve still commits to arch_out.
- Priority: reset > flush ≥ mispredict (identical effect on ghr/FIFO) > spec/resolve.
- Spec accept and a non-mispredicting resolve in the same cycle are both performed; count is unchanged. At count==DEPTH, spec_ready=0, so the push is refused even though a pop occurs (no pop bypass).
- Invariant, checked by assertion: with an empty FIFO, ghr_out == arch_out.

## Timing
- Reset values: ghr_out=0, arch_out=0, inflight_cnt=0, err_underflow=0, pointers=0, spec_ready=1, res_mispredict=0.
- Asserting rstn low mid-operation clears everything asynchronously. FIFO contents are don't-care.
- ghr_out reflects an accepted spec on the next rising edge (1-cycle latency). Back-to-back specs are supported every cycle.
- res_mispredict is valid in the same cycle as res_en. Recovered ghr_out is visible on the next edge.
- spec_ready and res_mispredict are combinational from registered state and current inputs; no combinational path from spec_en to spec_ready.

## Test plan
HIST_LEN=4, DEPTH=4 unless noted.
- **Reset:** rstn low, then high. Expect ghr_out=0000, arch_out=0000, inflight_cnt=0, spec_ready=1.
- **Speculative shift:** spec T, T, N on 3 cycles. Expect ghr_out 1000→1100→0110, arch_out=0000, inflight_cnt=3.
- **Correct resolve:** continuing, res_en with res_taken=1. Expect res_mispredict=0, arch_out=1000, ghr_out=0110, inflight_cnt=2.
- **Mispredict recovery:** from the previous state (head=T), res_taken=0 while spec_en=1. Expect res_mispredict=1; next cycle arch_out=0100, ghr_out=0100, inflight_cnt=0, and the spec is dropped.
- **Full / simultaneous / wrap:**
  - 4 specs T. Expect spec_ready=0.
  - A 5th spec_en is ignored: ghr_out stays 1111.
  - spec_en plus a correct res_en at full: pop only, inflight_cnt=3.
  - Then push and pop 8 more times. Pointers wrap and all commits are in order.
- **Flush / underflow:**
  - With 2 in flight, assert flush together with a correct res_en (taken). Expect arch_out to shift in 1, ghr_out=new arch_out, inflight_cnt=0.
  - Then res_en with the FIFO empty. Expect an err_underflow pulse for 1 cycle and no other state change.
